ifft_butterfly: RTL and testbench

Pipelined radix-2 inverse butterfly for the audio IFFT path, in the same s.12 format as the forward FFT core.
- Each forward stage computes y1=(x1+w*x2)/2 and y2=(x1-w*x2)/2.
- This block undoes that stage: x1 = y1+y2 and x2 = (y1-y2)*conj(w).
- It uses a 3-stage valid/ready pipeline with saturation and a sticky overflow flag.
- It sits between the spectrum-processing RAM and the IFFT stage sequencer, one instance per stage engine.

---
 rtl/fft_pkg.sv | 15 +
 rtl/sat_round.sv | 49 ++++
 rtl/ifft_butterfly.sv | 137 +++++++++++++
 tb/tb_ifft_butterfly.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT/IFFT datapath (s.12 samples).
package fft_pkg;

    localparam int DW      = 13;
    localparam int FRAC    = DW - 1;
    localparam int SAT_MAX = (1 << (DW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DW - 1));

    // One complex sample as a real/imaginary pair.
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sat_round.sv
// Round-half-up arithmetic right shift followed by saturation to OW bits.
// With SHIFT = 0 this is a plain saturating narrow.
module sat_round #(
    parameter int IW    = 14,
    parameter int OW    = 13,
    parameter int SHIFT = 0
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 sat
);

    // Limits expressed in the widened (IW+1) domain so comparisons are exact.
    localparam logic signed [IW:0] MAXV = (IW+1)'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [IW:0] MINV = ~MAXV;

    logic signed [IW:0] ext;
    logic signed [IW:0] biased;
    logic signed [IW:0] shifted;

    // One extra bit so adding the rounding constant can never wrap.
    assign ext = {din[IW-1], din};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [IW:0] HALF = (IW+1)'(64'sd1 <<< (SHIFT - 1));
            assign biased = ext + HALF;
        end else begin : g_noround
            assign biased = ext;
        end
    endgenerate

    // Arithmetic shift floors, so the added half gives round-half-up.
    assign shifted = biased >>> SHIFT;

    // Clamp to the output range and report whether clamping happened.
    always_comb begin
        sat  = 1'b0;
        dout = shifted[OW-1:0];
        if (shifted > MAXV) begin
            sat  = 1'b1;
            dout = MAXV[OW-1:0];
        end else if (shifted < MINV) begin
            sat  = 1'b1;
            dout = MINV[OW-1:0];
        end
    end

endmodule

// File: rtl/ifft_butterfly.sv
// Pipelined radix-2 inverse butterfly: x1 = y1+y2, x2 = (y1-y2)*conj(w).
// Three valid/ready stages: sum/difference, complex product, round+saturate.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Every stage loads when empty or when its contents move on in
// the same cycle, so bubbles collapse and a full pipe advances as a whole
// when the output is drained. in_ready depends only on stage valids and
// out_ready, never on in_valid.
module ifft_butterfly #(
    parameter int DW   = fft_pkg::DW,
    parameter int FRAC = DW - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    input  logic signed [DW-1:0] y1_re,
    input  logic signed [DW-1:0] y1_im,
    input  logic signed [DW-1:0] y2_re,
    input  logic signed [DW-1:0] y2_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x1_re,
    output logic signed [DW-1:0] x1_im,
    output logic signed [DW-1:0] x2_re,
    output logic signed [DW-1:0] x2_im,
    output logic                 sat_flag,
    input  logic                 sat_clr
);

    localparam int SW = DW + 1;       // exact sum/difference width
    localparam int PW = 2 * DW + 1;   // exact product-sum width

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    logic signed [SW-1:0] s1_re, s1_im, d1_re, d1_im;
    logic signed [DW-1:0] w1_re, w1_im;
    logic signed [SW-1:0] s2_re, s2_im;
    logic signed [PW-1:0] p2_re, p2_im;
    logic signed [PW-1:0] p_re_c, p_im_c;
    logic signed [DW-1:0] r1_re, r1_im, r2_re, r2_im;
    logic                 q1_re, q1_im, q2_re, q2_im;
    logic                 sat3;

    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    // Multiplying by conj(w): (d_re + j d_im)(w_re - j w_im).
    assign p_re_c = PW'(d1_re) * PW'(w1_re) + PW'(d1_im) * PW'(w1_im);
    assign p_im_c = PW'(d1_im) * PW'(w1_re) - PW'(d1_re) * PW'(w1_im);

    sat_round #(.IW(SW), .OW(DW), .SHIFT(0))    u_x1_re (.din(s2_re), .dout(r1_re), .sat(q1_re));
    sat_round #(.IW(SW), .OW(DW), .SHIFT(0))    u_x1_im (.din(s2_im), .dout(r1_im), .sat(q1_im));
    sat_round #(.IW(PW), .OW(DW), .SHIFT(FRAC)) u_x2_re (.din(p2_re), .dout(r2_re), .sat(q2_re));
    sat_round #(.IW(PW), .OW(DW), .SHIFT(FRAC)) u_x2_im (.din(p2_im), .dout(r2_im), .sat(q2_im));

    // Stage 1: exact sum and difference, twiddle captured alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            s1_re <= '0;
            s1_im <= '0;
            d1_re <= '0;
            d1_im <= '0;
            w1_re <= '0;
            w1_im <= '0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_re <= SW'(y1_re) + SW'(y2_re);
                s1_im <= SW'(y1_im) + SW'(y2_im);
                d1_re <= SW'(y1_re) - SW'(y2_re);
                d1_im <= SW'(y1_im) - SW'(y2_im);
                w1_re <= w_re;
                w1_im <= w_im;
            end
        end
    end

    // Stage 2: full-precision product with conj(w); sum passes through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            s2_re <= '0;
            s2_im <= '0;
            p2_re <= '0;
            p2_im <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                s2_re <= s1_re;
                s2_im <= s1_im;
                p2_re <= p_re_c;
                p2_im <= p_im_c;
            end
        end
    end

    // Stage 3: output register holding rounded, saturated results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3    <= 1'b0;
            x1_re <= '0;
            x1_im <= '0;
            x2_re <= '0;
            x2_im <= '0;
            sat3  <= 1'b0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                x1_re <= r1_re;
                x1_im <= r1_im;
                x2_re <= r2_re;
                x2_im <= r2_im;
                sat3  <= q1_re | q1_im | q2_re | q2_im;
            end
        end
    end

    // Sticky saturation flag; a saturating output transfer beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (v3 && out_ready && sat3) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifft_butterfly.sv
// Bench for ifft_butterfly: behavioural model + expected queue, one compare
// process on the falling edge, directed cases with literal expectations and
// a randomized forward/inverse round-trip run.
module tb_ifft_butterfly;

    localparam int DW   = 13;
    localparam int FRAC = 12;
    localparam int ONE  = 4096;
    localparam int HALF = 2048;
    localparam int SMAX = 4095;
    localparam int SMIN = -4096;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] w_re = '0, w_im = '0;
    logic signed [DW-1:0] y1_re = '0, y1_im = '0, y2_re = '0, y2_im = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] x1_re, x1_im, x2_re, x2_im;
    logic                 sat_flag;
    logic                 sat_clr = 1'b0;

    typedef struct {
        int x1r, x1i, x2r, x2i;
        bit sat;
        bit fwd;
        int o1r, o1i, o2r, o2i;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    bit   mdl_flag = 1'b0;
    bit   rnd_or   = 1'b0;
    bit   cur_fwd  = 1'b0;
    int   cur_o1r = 0, cur_o1i = 0, cur_o2r = 0, cur_o2i = 0;

    int tw_re[6] = '{0, -4096, 2896, -2896, 2896, 3784};
    int tw_im[6] = '{-4096, 0, -2896, -2896, 2896, -1567};

    ifft_butterfly dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .w_re(w_re), .w_im(w_im),
        .y1_re(y1_re), .y1_im(y1_im), .y2_re(y2_re), .y2_im(y2_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .x1_re(x1_re), .x1_im(x1_im), .x2_re(x2_re), .x2_im(x2_im),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Random backpressure while enabled.
    always @(posedge clk) begin
        if (rnd_or) begin
            #2;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- model ----------------
    function automatic int clamp(int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic bit outside(int v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    function automatic int floor_div(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic exp_t model(int y1r, int y1i, int y2r, int y2i, int wr, int wi);
        exp_t r;
        int sr, si, dr, di, pr, pi, xr, xi;
        sr = y1r + y2r;
        si = y1i + y2i;
        dr = y1r - y2r;
        di = y1i - y2i;
        pr = dr * wr + di * wi;
        pi = di * wr - dr * wi;
        xr = floor_div(pr + HALF, ONE);
        xi = floor_div(pi + HALF, ONE);
        r.x1r = clamp(sr);
        r.x1i = clamp(si);
        r.x2r = clamp(xr);
        r.x2i = clamp(xi);
        r.sat = outside(sr) || outside(si) || outside(xr) || outside(xi);
        r.fwd = 1'b0;
        r.o1r = 0; r.o1i = 0; r.o2r = 0; r.o2i = 0;
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int orig);
        int diff;
        checks++;
        diff = act - orig;
        if (diff > 2 || diff < -2) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d+-2", name, act, orig);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        bit   next_flag;
        if (rst) begin
            exp_q.delete();
            mdl_flag = 1'b0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_sat_flag", int'(sat_flag), 0);
        end else begin
            chk("sat_flag", int'(sat_flag), int'(mdl_flag));
            next_flag = mdl_flag;
            if (sat_clr) next_flag = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("x1_re", int'(x1_re), e.x1r);
                    chk("x1_im", int'(x1_im), e.x1i);
                    chk("x2_re", int'(x2_re), e.x2r);
                    chk("x2_im", int'(x2_im), e.x2i);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (e.sat) next_flag = 1'b1;
                        if (e.fwd) begin
                            chk_tol("recon_x1_re", int'(x1_re), e.o1r);
                            chk_tol("recon_x1_im", int'(x1_im), e.o1i);
                            chk_tol("recon_x2_re", int'(x2_re), e.o2r);
                            chk_tol("recon_x2_im", int'(x2_im), e.o2i);
                        end
                    end
                end
            end
            mdl_flag = next_flag;
            if (in_valid && in_ready) begin
                e = model(int'(y1_re), int'(y1_im), int'(y2_re), int'(y2_im),
                          int'(w_re), int'(w_im));
                e.fwd = cur_fwd;
                e.o1r = cur_o1r; e.o1i = cur_o1i; e.o2r = cur_o2r; e.o2i = cur_o2i;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic set_raw(input int a, input int b, input int c, input int d,
                           input int wr, input int wi);
        y1_re = DW'(a); y1_im = DW'(b);
        y2_re = DW'(c); y2_im = DW'(d);
        w_re  = DW'(wr); w_im = DW'(wi);
        cur_fwd = 1'b0;
        in_valid = 1'b1;
    endtask

    // Random original pair pushed through a truncating forward butterfly.
    task automatic set_fwd();
        int a, b, c, d, k, tr, ti;
        a = int'($urandom_range(0, 2000)) - 1000;
        b = int'($urandom_range(0, 2000)) - 1000;
        c = int'($urandom_range(0, 2000)) - 1000;
        d = int'($urandom_range(0, 2000)) - 1000;
        k = int'($urandom_range(0, 5));
        tr = (tw_re[k] * c - tw_im[k] * d) >>> FRAC;
        ti = (tw_re[k] * d + tw_im[k] * c) >>> FRAC;
        set_raw((a + tr) >>> 1, (b + ti) >>> 1, (a - tr) >>> 1, (b - ti) >>> 1,
                tw_re[k], tw_im[k]);
        cur_fwd = 1'b1;
        cur_o1r = a; cur_o1i = b; cur_o2r = c; cur_o2i = d;
    endtask

    // Hold the current operands until accepted (bounded).
    task automatic push_wait();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            ok = in_ready;
            acc_cyc = cyc;
            sync();
            if (ok) break;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        bit seen;
        seen = 1'b0;
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("output_timeout", 0, 1);
        else lat = cyc - acc_cyc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int guard;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_x1_re", int'(x1_re), 0);
        chk("reset_x2_im", int'(x2_im), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        sync();
        rst = 1'b0;
        out_ready = 1'b1;
        sync();

        // Pure rotation by conj(-j), latency check.
        set_raw(512, -256, 512, 256, 0, -4096);
        push_wait();
        idle();
        wait_out(lat);
        chk("latency", lat, 3);
        chk("t1_x1_re", int'(x1_re), 1024);
        chk("t1_x1_im", int'(x1_im), 0);
        chk("t1_x2_re", int'(x2_re), 512);
        chk("t1_x2_im", int'(x2_im), 0);
        chk("t1_sat_flag", int'(sat_flag), 0);
        sync();

        // Saturating sum, sticky flag, then clear.
        set_raw(4000, 0, 4000, 0, 2048, 0);
        push_wait();
        idle();
        wait_out(lat);
        chk("t2_x1_re", int'(x1_re), 4095);
        chk("t2_x2_re", int'(x2_re), 0);
        sync();
        @(negedge clk);
        #1;
        chk("t2_flag_set", int'(sat_flag), 1);
        sync();
        sat_clr = 1'b1;
        sync();
        sat_clr = 1'b0;
        @(negedge clk);
        #1;
        chk("t2_flag_clr", int'(sat_flag), 0);
        sync();

        // Half-up rounding at +0.5 and -0.5.
        set_raw(1, 0, 0, 0, 2048, 0);
        push_wait();
        idle();
        wait_out(lat);
        chk("t3_round_pos", int'(x2_re), 1);
        sync();
        set_raw(-1, 0, 0, 0, 2048, 0);
        push_wait();
        idle();
        wait_out(lat);
        chk("t3_round_neg", int'(x2_re), 0);
        chk("t3_x1_re", int'(x1_re), -1);
        sync();

        // Backpressure: pipe fills after three accepts, then drains in order.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_fwd();
            push_wait();
        end
        set_fwd();
        repeat (4) sync();
        @(negedge clk);
        #1;
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_accepts", exp_q.size(), 3);
        chk("full_out_valid", int'(out_valid), 1);
        sync();
        out_ready = 1'b1;
        push_wait();
        for (int i = 4; i < 8; i++) begin
            set_fwd();
            push_wait();
        end
        idle();
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            sync();
            guard++;
        end
        chk("bp_drained", exp_q.size(), 0);

        // Randomized round trip with random gaps and backpressure.
        rnd_or = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_raw(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
                        int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
                        int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096);
            else
                set_fwd();
            push_wait();
            if ($urandom_range(0, 3) == 0) begin
                idle();
                sync();
            end
        end
        idle();
        rnd_or = 1'b0;
        sync();
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            sync();
            guard++;
        end
        chk("rand_drained", exp_q.size(), 0);
        sync();
        sat_clr = 1'b1;
        sync();
        sat_clr = 1'b0;
        sync();

        // Reset with two items in flight.
        set_raw(100, 200, 300, 400, 4095, 0);
        push_wait();
        set_raw(-100, 50, 20, -30, 0, 4095);
        push_wait();
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        sync();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("no_stale_output", int'(out_valid), 0);
        end
        sync();
        out_ready = 1'b1;
        set_raw(512, -256, 512, 256, 0, -4096);
        push_wait();
        idle();
        wait_out(lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_x1_re", int'(x1_re), 1024);
        chk("post_rst_x2_re", int'(x2_re), 512);
        repeat (4) sync();
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
